// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared constants and helpers for the four-master bus arbiter.
// Owner encodings, decision codes and the active-low grant decode.
package yutorina_bus_arbiter_pkg;

    localparam int BUS_MASTERS = 4;
    localparam int BUS_OWNER_W = 2;

    typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

    localparam bus_owner_t BUS_OWNER_M0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_M1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_M2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_M3 = 2'd3;

    typedef enum logic [1:0] {
        ARB_RELEASE,
        ARB_PARK,
        ARB_PREEMPT,
        ARB_HOLD
    } arb_decision_e;

    // Active-low grant vector: only the owner's bit is 0.
    function automatic logic [BUS_MASTERS-1:0] grant_decode(input bus_owner_t owner);
        return ~(4'b0001 << owner);
    endfunction

endpackage

// File: rtl/yutorina_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// The master side drives requests and the bus strobe; the arbiter drives grants and owner.
interface yutorina_bus_arbiter_if;
    import yutorina_bus_arbiter_pkg::*;

    logic       m0_req_;
    logic       m1_req_;
    logic       m2_req_;
    logic       m3_req_;
    logic       bus_as_;
    logic       m0_grnt_;
    logic       m1_grnt_;
    logic       m2_grnt_;
    logic       m3_grnt_;
    bus_owner_t owner;

    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_, bus_as_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner
    );

    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_, bus_as_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner
    );

endinterface

// File: rtl/yutorina_bus_rr_pick.sv
// Rotated priority encoder: nearest requester after the current owner, owner excluded.
module yutorina_bus_rr_pick
    import yutorina_bus_arbiter_pkg::*;
(
    input  logic [BUS_MASTERS-1:0] req,
    input  bus_owner_t             owner,
    output logic                   candidate_valid,
    output bus_owner_t             candidate
);

    // Scan farthest-to-nearest so the nearest requester is the last one written.
    always_comb begin
        bus_owner_t idx;
        candidate_valid = 1'b0;
        candidate       = owner;
        idx             = owner;
        for (int k = BUS_MASTERS - 1; k >= 1; k--) begin
            idx = owner + bus_owner_t'(k);
            if (req[idx]) begin
                candidate_valid = 1'b1;
                candidate       = idx;
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with parking and tenure-limited preemption.
//   decision    | meaning
//   ARB_RELEASE | owner dropped its request, hand over to nearest requester
//   ARB_PARK    | owner dropped its request, nobody waiting, keep owner
//   ARB_PREEMPT | tenure expired, bus idle, others waiting: rotate
//   ARB_HOLD    | owner keeps the bus, tenure counter advances (saturating)
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    yutorina_bus_arbiter_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] PRE_THR  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    bus_owner_t              owner_q;
    bus_owner_t              owner_d;
    logic [HOLD_W-1:0]       hold_q;
    logic [HOLD_W-1:0]       hold_d;
    logic [BUS_MASTERS-1:0]  grnt_q;
    logic [BUS_MASTERS-1:0]  req;
    logic                    candidate_valid;
    bus_owner_t              candidate;
    arb_decision_e           decision;

    assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

    yutorina_bus_rr_pick u_pick (
        .req             (req),
        .owner           (owner_q),
        .candidate_valid (candidate_valid),
        .candidate       (candidate)
    );

    always_comb begin
        decision = ARB_HOLD;
        owner_d  = owner_q;
        hold_d   = hold_q;

        if (!req[owner_q]) begin
            decision = candidate_valid ? ARB_RELEASE : ARB_PARK;
        end else if ((MAX_HOLD != 0) && (hold_q >= PRE_THR) && candidate_valid && bus.bus_as_) begin
            decision = ARB_PREEMPT;
        end

        unique case (decision)
            ARB_RELEASE, ARB_PREEMPT: begin
                owner_d = candidate;
                hold_d  = '0;
            end
            ARB_PARK: begin
                hold_d = '0;
            end
            ARB_HOLD: begin
                if (hold_q != HOLD_SAT) hold_d = hold_q + HOLD_W'(1);
            end
            default: begin
                owner_d = owner_q;
                hold_d  = hold_q;
            end
        endcase
    end

    // Grants are registered from the next owner so they leave flops directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= BUS_OWNER_M0;
            hold_q  <= '0;
            grnt_q  <= grant_decode(BUS_OWNER_M0);
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grnt_q  <= grant_decode(owner_d);
        end
    end

    assign bus.m0_grnt_ = grnt_q[0];
    assign bus.m1_grnt_ = grnt_q[1];
    assign bus.m2_grnt_ = grnt_q[2];
    assign bus.m3_grnt_ = grnt_q[3];
    assign bus.owner    = owner_q;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Bench for the round-robin arbiter: two instances (MAX_HOLD 4 and 0) share stimulus,
// each is compared every cycle against a behavioural model, plus directed literal checks.
module tb_yutorina_bus_arbiter;
    import yutorina_bus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_n;
    logic       as_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    yutorina_bus_arbiter_if bus4 ();
    yutorina_bus_arbiter_if bus0 ();

    assign bus4.m0_req_ = req_n[0];
    assign bus4.m1_req_ = req_n[1];
    assign bus4.m2_req_ = req_n[2];
    assign bus4.m3_req_ = req_n[3];
    assign bus4.bus_as_ = as_n;
    assign bus0.m0_req_ = req_n[0];
    assign bus0.m1_req_ = req_n[1];
    assign bus0.m2_req_ = req_n[2];
    assign bus0.m3_req_ = req_n[3];
    assign bus0.bus_as_ = as_n;

    yutorina_bus_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    yutorina_bus_arbiter #(.MAX_HOLD(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    logic [3:0] g4, g0;
    assign g4 = {bus4.m3_grnt_, bus4.m2_grnt_, bus4.m1_grnt_, bus4.m0_grnt_};
    assign g0 = {bus0.m3_grnt_, bus0.m2_grnt_, bus0.m1_grnt_, bus0.m0_grnt_};

    // Model: owner index and number of edges the owner has kept the bus.
    int m_own[2] = '{0, 0};
    int m_ten[2] = '{0, 0};
    int mh[2]    = '{4, 0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_own[i] = 0;
                m_ten[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int cand;
                cand = -1;
                for (int d = 3; d >= 1; d--)
                    if (!req_n[(m_own[i] + d) % 4]) cand = (m_own[i] + d) % 4;
                if (req_n[m_own[i]]) begin
                    if (cand >= 0) m_own[i] = cand;
                    m_ten[i] = 0;
                end else if (mh[i] != 0 && m_ten[i] + 1 >= mh[i] && cand >= 0 && as_n) begin
                    m_own[i] = cand;
                    m_ten[i] = 0;
                end else if (m_ten[i] < mh[i]) begin
                    m_ten[i] = m_ten[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string nm, input logic [3:0] g, input logic [1:0] o, input int exp_own);
        logic [3:0] exp_g;
        exp_g = 4'hF;
        exp_g[exp_own] = 1'b0;
        chk({nm, " owner"}, int'(o), exp_own);
        chk({nm, " grants"}, int'(g), int'(exp_g));
        chk({nm, " one_grant"}, $countones(~g), 1);
    endtask

    always @(negedge clk) begin
        chk_dut("dut4", g4, bus4.owner, m_own[0]);
        chk_dut("dut0", g0, bus0.owner, m_own[1]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        req_n = 4'hF;
        as_n  = 1'b1;
        #12 reset = 1'b0;

        // Idle after reset: parked on m0.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle owner4", bus4.owner, 0);
            chk("idle owner0", bus0.owner, 0);
            chk("idle m0_grnt4", bus4.m0_grnt_, 0);
        end

        // Release chain 0 -> 2 -> 3 -> 0.
        as_n  = 1'b0;
        req_n = 4'b0010;
        tick();
        chk("chain hold", bus4.owner, 0);
        req_n = 4'b0011;
        tick();
        chk("chain to2 d4", bus4.owner, 2);
        chk("chain to2 d0", bus0.owner, 2);
        req_n = 4'b0111;
        tick();
        chk("chain to3", bus4.owner, 3);
        req_n = 4'b1110;
        tick();
        chk("chain to0", bus4.owner, 0);

        // Forced rotation on 4th edge of m1's tenure.
        req_n = 4'b1101;
        tick();
        chk("m1 acquire d4", bus4.owner, 1);
        chk("m1 acquire d0", bus0.owner, 1);
        req_n = 4'b1001;
        as_n  = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("tenure keep", bus4.owner, 1);
        end
        tick();
        chk("preempt d4", bus4.owner, 2);
        chk("no preempt d0", bus0.owner, 1);

        // Expired tenure blocked while bus_as_ = 0.
        req_n = 4'b1101;
        as_n  = 1'b0;
        tick();
        chk("m1 reacquire", bus4.owner, 1);
        req_n = 4'b1001;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("as_ blocks", bus4.owner, 1);
        end
        as_n = 1'b1;
        tick();
        chk("as_ release rotates", bus4.owner, 2);
        chk("as_ d0 stays", bus0.owner, 1);

        // MAX_HOLD = 0: m3 never loses the bus.
        req_n = 4'b0111;
        tick();
        chk("m3 acquire d0", bus0.owner, 3);
        chk("m3 acquire d4", bus4.owner, 3);
        req_n = 4'b0000;
        for (int e = 0; e < 100; e++) begin
            tick();
            chk("nohold m3", bus0.owner, 3);
        end

        // Park on last owner.
        req_n = 4'hF;
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("park d0", bus0.owner, 3);
        end

        // Async reset between edges while owner = 2.
        req_n = 4'b1011;
        tick();
        chk("pre-reset own2", bus4.owner, 2);
        #1 reset = 1'b1;
        #1;
        chk("async m0_grnt4", bus4.m0_grnt_, 0);
        chk("async m2_grnt4", bus4.m2_grnt_, 1);
        chk("async owner4", bus4.owner, 0);
        chk("async m0_grnt0", bus0.m0_grnt_, 0);
        reset = 1'b0;
        req_n = 4'b1100;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("post-reset tenure", bus4.owner, 0);
        end
        tick();
        chk("post-reset preempt", bus4.owner, 1);
        chk("post-reset d0", bus0.owner, 0);

        // Randomized traffic with occasional async resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req_n = 4'($urandom_range(0, 15));
            as_n = ($urandom_range(0, 3) != 0);
            tick();
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
